// File: rtl/ext_bus_slave_mem_pkg.sv
// Shared definitions for the external-bus slave memory:
// transfer size codes, slave FSM states and wait-state bounds.
package ext_bus_slave_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACK  = 2'b01,
        S_WAIT = 2'b10,
        S_DATA = 2'b11
    } state_e;

    // Legal data-phase wait states between the two rdy pulses.
    localparam int WAIT_MIN = 2;
    localparam int WAIT_MAX = 15;
    localparam int WCNT_W   = 4;

endpackage

// File: rtl/ext_bus_slave_mem_if.sv
// External bus between a master and the slave memory.
// Request: en/we/size/addr/data/oe; response: rdy/data/err.
interface ext_bus_slave_mem_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  bus_en_i;
    logic                  bus_we_i;
    logic [1:0]            bus_size_i;
    logic [ADDR_WIDTH-1:0] bus_addr_i;
    logic [DATA_WIDTH-1:0] bus_data_i;
    logic                  bus_data_oe_i;
    logic                  slv_rdy_o;
    logic [DATA_WIDTH-1:0] slv_data_o;
    logic                  slv_err_o;

    modport slave (
        input  bus_en_i,
        input  bus_we_i,
        input  bus_size_i,
        input  bus_addr_i,
        input  bus_data_i,
        input  bus_data_oe_i,
        output slv_rdy_o,
        output slv_data_o,
        output slv_err_o
    );

    modport master (
        output bus_en_i,
        output bus_we_i,
        output bus_size_i,
        output bus_addr_i,
        output bus_data_i,
        output bus_data_oe_i,
        input  slv_rdy_o,
        input  slv_data_o,
        input  slv_err_o
    );
endinterface

// File: rtl/ext_bus_slave_mem_lane.sv
// Byte-lane unit: size+lane -> byte enables and misalign flag,
// write-data shift to lane, read-data extract with zero-extension.
// Ports: size_i, lane_i, wdata_i, rword_i in; be_o, misalign_o,
// wdata_o (lane-shifted), rdata_o (right-justified) out.
module ext_bus_slave_mem_lane
    import ext_bus_slave_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  size_e                 size_i,
    input  logic [1:0]            lane_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rword_i,
    output logic [3:0]            be_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [4:0]            sh;
    logic [DATA_WIDTH-1:0] rshift;

    assign sh      = {lane_i, 3'b000};
    assign wdata_o = wdata_i << sh;
    assign rshift  = rword_i >> sh;

    // Reserved size is folded into misalign so the top sees a
    // single request-error source from this unit.
    always_comb begin
        be_o       = 4'b0000;
        misalign_o = 1'b0;
        rdata_o    = '0;
        unique case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << lane_i;
                rdata_o = {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]};
            end
            SZ_HALF: begin
                be_o       = 4'b0011 << lane_i;
                misalign_o = lane_i[0];
                rdata_o    = {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]};
            end
            SZ_WORD: begin
                be_o       = 4'b1111;
                misalign_o = |lane_i;
                rdata_o    = rshift;
            end
            SZ_RSVD: begin
                misalign_o = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/ext_bus_slave_mem.sv
// Slave memory behind the external bus: two-pulse rdy handshake
// (request ack, then data complete) with WAIT_CYCLES wait states.
// Ports: clk, reset_n (async, active low); bus (slave modport):
// en/we/size/addr/data/oe in, rdy/data/err out.
module ext_bus_slave_mem
    import ext_bus_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ext_bus_slave_mem_if.slave   bus
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = $clog2(DEPTH);

    state_e                state_q, state_d;
    logic [WCNT_W-1:0]     cnt_q, cnt_d;
    logic                  we_q, we_d;
    size_e                 size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] rword;
    logic [DATA_WIDTH-1:0] wshift;
    logic [DATA_WIDTH-1:0] rdata;
    logic [3:0]            be;
    logic                  misalign;
    logic                  range_err;
    logic                  req_err;
    logic                  wr_en;

    assign idx       = addr_q[ADDR_WIDTH-1:2];
    assign range_err = 32'(idx) >= 32'(DEPTH);
    assign req_err   = misalign | range_err;
    assign rword     = mem[idx[MW-1:0]];

    ext_bus_slave_mem_lane #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .size_i     (size_q),
        .lane_i     (addr_q[1:0]),
        .wdata_i    (bus.bus_data_i),
        .rword_i    (rword),
        .be_o       (be),
        .misalign_o (misalign),
        .wdata_o    (wshift),
        .rdata_o    (rdata)
    );

    // A write missing its data-valid is only known in S_DATA, so
    // err is decoded from state rather than registered ahead.
    assign bus.slv_rdy_o  = rdy_q;
    assign bus.slv_data_o = data_q;
    assign bus.slv_err_o  = (state_q == S_DATA) &
                            (req_err | (we_q & ~bus.bus_data_oe_i));

    assign wr_en = (state_q == S_DATA) & we_q &
                   bus.bus_data_oe_i & ~req_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdy_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.bus_en_i) begin
                    we_d    = bus.bus_we_i;
                    size_d  = size_e'(bus.bus_size_i);
                    addr_d  = bus.bus_addr_i;
                    state_d = S_ACK;
                    rdy_d   = 1'b1;
                    if (bus.bus_we_i) begin
                        data_d = '0;
                    end
                end
            end
            S_ACK: begin
                cnt_d   = WCNT_W'(WAIT_CYCLES - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    rdy_d   = 1'b1;
                    if (!we_q) begin
                        data_d = req_err ? '0 : rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            rdy_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            rdy_q   <= rdy_d;
            data_q  <= data_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx[MW-1:0]][8*b +: 8] <= wshift[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ext_bus_slave_mem.sv
// Directed bench for ext_bus_slave_mem, WAIT_CYCLES 2 and 5,
// with a scoreboard of expected responses.
module tb_ext_bus_slave_mem;
    import ext_bus_slave_mem_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic reset_n;
    int   nvec;
    int   nerr;
    exp_t sb [$];
    logic [31:0] mm [int];

    ext_bus_slave_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) ifc2 ();
    ext_bus_slave_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) ifc5 ();

    ext_bus_slave_mem #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32),
        .DEPTH(1024), .WAIT_CYCLES(2)
    ) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc2.slave)
    );

    ext_bus_slave_mem #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32),
        .DEPTH(1024), .WAIT_CYCLES(5)
    ) u_dut5 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic en,
                           input logic we, input logic [1:0] sz,
                           input logic [15:0] a,
                           input logic [31:0] wd, input logic oe);
        if (sel == 0) begin
            ifc2.bus_en_i = en;      ifc2.bus_we_i = we;
            ifc2.bus_size_i = sz;    ifc2.bus_addr_i = a;
            ifc2.bus_data_i = wd;    ifc2.bus_data_oe_i = oe;
        end else begin
            ifc5.bus_en_i = en;      ifc5.bus_we_i = we;
            ifc5.bus_size_i = sz;    ifc5.bus_addr_i = a;
            ifc5.bus_data_i = wd;    ifc5.bus_data_oe_i = oe;
        end
    endtask

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? ifc2.slv_rdy_o : ifc5.slv_rdy_o;
    endfunction

    function automatic logic [31:0] get_data(input int sel);
        return (sel == 0) ? ifc2.slv_data_o : ifc5.slv_data_o;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? ifc2.slv_err_o : ifc5.slv_err_o;
    endfunction

    function automatic logic m_err(input logic we,
                                   input logic [1:0] sz,
                                   input logic [15:0] a,
                                   input logic oe);
        return (sz == 2'b11) ||
               (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00) ||
               (a[15:2] >= 14'd1024) ||
               (we && !oe);
    endfunction

    function automatic int key(input int sel, input logic [15:0] a);
        return sel * 65536 + int'(a[15:2]);
    endfunction

    task automatic m_write(input int sel, input logic [1:0] sz,
                           input logic [15:0] a,
                           input logic [31:0] wd);
        logic [31:0] w;
        int k;
        k = key(sel, a);
        w = mm.exists(k) ? mm[k] : 32'h0;
        case (sz)
            2'b00:   w[8*a[1:0] +: 8] = wd[7:0];
            2'b01:   w[16*a[1] +: 16] = wd[15:0];
            default: w = wd;
        endcase
        mm[k] = w;
    endtask

    function automatic logic [31:0] m_read(input int sel,
                                           input logic [1:0] sz,
                                           input logic [15:0] a);
        logic [31:0] w;
        logic [31:0] r;
        int k;
        k = key(sel, a);
        w = mm.exists(k) ? mm[k] : 32'h0;
        r = 32'h0;
        case (sz)
            2'b00:   r[7:0]  = w[8*a[1:0] +: 8];
            2'b01:   r[15:0] = w[16*a[1] +: 16];
            default: r = w;
        endcase
        return r;
    endfunction

    // One full transfer; checks both rdy timings, pulse count,
    // err and returned data against the scoreboard entry.
    task automatic xfer(input int sel, input logic we,
                        input logic [1:0] sz, input logic [15:0] a,
                        input logic [31:0] wd, input logic oe,
                        input logic hold);
        exp_t e;
        exp_t g;
        int w;
        int t1;
        int t2;
        int np;
        logic [31:0] rd;
        logic er;
        w = (sel == 0) ? 2 : 5;
        e.err = m_err(we, sz, a, oe);
        e.data = 32'h0;
        if (!e.err) begin
            if (we) m_write(sel, sz, a, wd);
            else    e.data = m_read(sel, sz, a);
        end
        sb.push_back(e);
        set_req(sel, 1'b1, we, sz, a, wd, oe);
        t1 = -1;
        t2 = -1;
        np = 0;
        rd = 'x;
        er = 1'bx;
        for (int t = 1; t <= w + 6; t++) begin
            @(posedge clk);
            #1;
            if (get_rdy(sel)) begin
                np++;
                if (t1 < 0) begin
                    t1 = t;
                end else if (t2 < 0) begin
                    t2 = t;
                    rd = get_data(sel);
                    er = get_err(sel);
                end
            end
            if (t2 >= 0 && t > t2) begin
                set_req(sel, 1'b0, we, sz, a, wd, 1'b0);
            end else if (t2 >= 0 || (!hold && t1 >= 0 && t > t1)) begin
                set_req(sel, 1'b0, we, sz, a, wd, oe);
            end
        end
        set_req(sel, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0, 1'b0);
        chk("first_rdy", t1, 1);
        chk("second_rdy", t2, 2 + w);
        chk("rdy_pulses", np, 2);
        g = sb.pop_front();
        chk("err", {31'b0, er}, {31'b0, g.err});
        chk("rdata", rd, g.data);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0, 1'b0);
        set_req(1, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy2",  {31'b0, ifc2.slv_rdy_o}, 32'h0);
        chk("rst_data2", ifc2.slv_data_o, 32'h0);
        chk("rst_err2",  {31'b0, ifc2.slv_err_o}, 32'h0);
        chk("rst_rdy5",  {31'b0, ifc5.slv_rdy_o}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Word write then read.
        xfer(0, 1'b1, SZ_WORD, 16'h0010, 32'hDEADBEEF, 1'b1, 1'b0);
        xfer(0, 1'b0, SZ_WORD, 16'h0010, 32'h0, 1'b0, 1'b0);
        chk("t1_model", m_read(0, SZ_WORD, 16'h0010), 32'hDEADBEEF);

        // Byte and half lanes.
        xfer(0, 1'b1, SZ_WORD, 16'h0020, 32'h00000000, 1'b1, 1'b0);
        xfer(0, 1'b1, SZ_BYTE, 16'h0022, 32'hFFFFFFAB, 1'b1, 1'b0);
        xfer(0, 1'b1, SZ_HALF, 16'h0020, 32'hEEEE1234, 1'b1, 1'b0);
        xfer(0, 1'b0, SZ_WORD, 16'h0020, 32'h0, 1'b0, 1'b0);
        xfer(0, 1'b0, SZ_BYTE, 16'h0022, 32'h0, 1'b0, 1'b0);
        xfer(0, 1'b0, SZ_HALF, 16'h0022, 32'h0, 1'b0, 1'b0);
        chk("t2_model", m_read(0, SZ_WORD, 16'h0020), 32'h00AB1234);

        // Misaligned, reserved size, write without data-valid.
        xfer(0, 1'b1, SZ_WORD, 16'h0030, 32'hCAFEF00D, 1'b1, 1'b0);
        xfer(0, 1'b1, SZ_HALF, 16'h0031, 32'h00009999, 1'b1, 1'b0);
        xfer(0, 1'b0, SZ_WORD, 16'h0032, 32'h0, 1'b0, 1'b0);
        xfer(0, 1'b0, SZ_RSVD, 16'h0030, 32'h0, 1'b0, 1'b0);
        xfer(0, 1'b1, SZ_WORD, 16'h0030, 32'h11111111, 1'b0, 1'b0);
        xfer(0, 1'b0, SZ_WORD, 16'h0030, 32'h0, 1'b0, 1'b0);

        // Out of range and top valid word.
        xfer(0, 1'b1, SZ_WORD, 16'h0000, 32'h01020304, 1'b1, 1'b0);
        xfer(0, 1'b1, SZ_WORD, 16'h1000, 32'hFFFFFFFF, 1'b1, 1'b0);
        xfer(0, 1'b0, SZ_WORD, 16'h0000, 32'h0, 1'b0, 1'b0);
        xfer(0, 1'b1, SZ_WORD, 16'h0FFC, 32'hA5A5C3C3, 1'b1, 1'b0);
        xfer(0, 1'b0, SZ_WORD, 16'h0FFC, 32'h0, 1'b0, 1'b0);

        // Reset during the wait phase of a write.
        xfer(0, 1'b1, SZ_WORD, 16'h0040, 32'h11112222, 1'b1, 1'b0);
        set_req(0, 1'b1, 1'b1, SZ_WORD, 16'h0040, 32'h55AA55AA, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ifc2.slv_rdy_o}, 32'h1);
        set_req(0, 1'b0, 1'b1, SZ_WORD, 16'h0040, 32'h55AA55AA, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_rdy_now", {31'b0, ifc2.slv_rdy_o}, 32'h0);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("rst_rdy_hold", {31'b0, ifc2.slv_rdy_o}, 32'h0);
        end
        set_req(0, 1'b0, 1'b0, SZ_BYTE, 16'h0, 32'h0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(0, 1'b0, SZ_WORD, 16'h0040, 32'h0, 1'b0, 1'b0);

        // Back-to-back alternating traffic, en held through ack.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) begin
                logic [15:0] a;
                logic [31:0] d;
                a = 16'h0100 + 16'(4 * i);
                d = 32'h13579BDF ^ (32'(i + 1) * 32'h01010101);
                xfer(s, 1'b1, SZ_WORD, a, d, 1'b1, 1'b1);
                xfer(s, 1'b0, SZ_WORD, a, 32'h0, 1'b0, 1'b1);
            end
            xfer(s, 1'b0, SZ_BYTE, 16'h0107, 32'h0, 1'b0, 1'b1);
        end

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end
endmodule
